tty_hex_tx: RTL
===============

# tty_hex_tx

Formats a binary word as ASCII hexadecimal text and streams the characters one byte at a time into `tty_tx`. It sits directly upstream of `tty_tx`. It takes debug and status words from the core over a valid/ready handshake and produces `"0x" + digits + CR LF` on the serial console. Each character is held until `tty_tx` acknowledges it.

## Interface
- `WIDTH`, 32, bit width of the input word; must be a multiple of 4; digit count NDIG = WIDTH/4.
- `PREFIX`, 1, when 1 emit `"0x"` (0x30, 0x78) before the digits.
- `NEWLINE`, 1, when 1 emit CR LF (0x0D, 0x0A) after the digits.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  block idle and able to accept a word.
- `in_data`  in  WIDTH  word to print.
- `tx_valid`  out  1  character available to `tty_tx` (drives its `valid`).
- `tx_data`  out  8  ASCII character (drives `tty_tx` `data`).
- `tx_ready`  in  1  one-cycle end-of-frame pulse from `tty_tx` (its `ready`).

## Operation
- States: IDLE, PFX0, PFX1, DIGIT, CR, LF.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready` at an edge: capture `in_data` into a WIDTH-bit shift register and load the digit counter with NDIG-1.
  - Next state is PFX0 if PREFIX, else DIGIT.
- PFX0 -> PFX1 -> DIGIT. Each transition occurs on an edge where `tx_ready`=1.
- DIGIT:
  - `tx_data` = ASCII of shift register bits [WIDTH-1:WIDTH-4]. Values 0-9 map to 0x30-0x39; values A-F map to 0x41-0x46 (uppercase).
  - On `tx_ready`: shift left by 4 and decrement the counter.
  - When the counter is 0 at `tx_ready`: go to CR if NEWLINE, else IDLE.
- CR -> LF -> IDLE on `tx_ready`.
- `tx_data` is a function of state and shift-register head only. It is constant for the whole time a character is presented. In IDLE it is 0x00.
- `tx_valid = (state != IDLE) && !tx_ready` (combinational mask).
  - `tty_tx` samples `valid` on the same edge that this block advances. The mask drops valid for that one cycle, which prevents a duplicate start with the stale byte.
  - `tty_tx` only pulses `ready` if `valid` is held through the frame, so `tx_valid` must stay high from character start until the `tx_ready` pulse.
- `tx_ready` in IDLE is ignored.
- `in_valid` while not IDLE is ignored. The word is not captured.
- The arithmetic counter is ceil(log2(NDIG)) bits wide and never wraps. The counter-0 exit is checked before decrement.

## Timing
- Reset values: `in_ready`=1, `tx_valid`=0, `tx_data`=0x00, state IDLE, shift register 0, counter 0.
- Reset mid-word: state goes to IDLE immediately (asynchronously) and the remaining characters are discarded. `tty_tx` shares `rstb`.
- Accept on edge E: `tx_valid`=1 from the cycle after E with the first character.
- Per character:
  - `tx_valid` is high until `tty_tx` pulses `tx_ready` in cycle R.
  - `tx_valid` is low in cycle R.
  - The block advances at edge R+1; `tx_valid` is high again with the next character from R+1.
  - `tty_tx` starts that frame at edge R+2.
- Characters per word: N = 2·PREFIX + NDIG + 2·NEWLINE (12 at defaults).
- After the last `tx_ready` pulse (cycle R), `in_ready`=1 from R+1. The earliest next accept is edge R+2.
- There is no internal timeout. The block stalls indefinitely while `tx_ready` is absent.
- Throughput is bounded by `tty_tx`: one word takes about N·10 bit-times plus 2 cycles.

## Test plan
- Defaults, `in_data`=0xDEADBEEF -> bytes 30 78 44 45 41 44 42 45 45 46 0D 0A in order, each presented exactly once. `in_ready` is low throughout and high the cycle after the LF ack.
- Defaults, `in_data`=0x00000000 -> "0x00000000\r\n". Also cover `in_data`=0x0123ABCF -> digit bytes 30 31 32 33 41 42 43 46.
- WIDTH=8, PREFIX=0, NEWLINE=0, `in_data`=0xA5 -> bytes 41 35 only; `in_ready` returns after 2 acks.
- Hold `in_valid` high with 0x11111111 then 0x22222222 against a `tty_tx` model (400-cycle bit period) -> two 12-char lines, no duplicated or dropped byte. `tx_valid` is low in each `tx_ready` cycle. The second word is accepted exactly one edge after `in_ready` rises.
- Stall: delay `tx_ready` 1000 cycles on the 3rd character -> `tx_valid`=1 and `tx_data`=0x44 stable the whole time. `in_valid` pulses during the stall are not captured.
- Pull `rstb` low during the 5th character -> `tx_valid`=0, `in_ready`=1, `tx_data`=0x00 immediately. The next word prints from 0x30 0x78 with no residual digits.

Source files
------------

// File: rtl/tty_hex_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : tty_hex_tx_if
// Brief    : Word-in / character-out handshake bundle for tty_hex_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface tty_hex_tx_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;

    modport slave (
        input  in_valid, in_data, tx_ready,
        output in_ready, tx_valid, tx_data
    );

    modport master (
        output in_valid, in_data, tx_ready,
        input  in_ready, tx_valid, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/tty_hex_tx.sv
`default_nettype none
// ============================================================================
// Module   : tty_hex_tx
// Brief    : Prints a WIDTH-bit word as "0x" + uppercase hex digits + CR LF,
//            one character per tty_tx frame.
// Revision : 1.0 - initial release
// ============================================================================
module tty_hex_tx #(
    parameter int WIDTH   = 32,
    parameter int PREFIX  = 1,
    parameter int NEWLINE = 1
) (
    input  wire logic   clk,
    input  wire logic   rstb,
    tty_hex_tx_if.slave bus
);

    localparam int NDIG = WIDTH / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PFX0  = 3'd1;
    localparam logic [2:0] S_PFX1  = 3'd2;
    localparam logic [2:0] S_DIGIT = 3'd3;
    localparam logic [2:0] S_CR    = 3'd4;
    localparam logic [2:0] S_LF    = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic [3:0]       w_nib;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_nib    = r_shift[WIDTH-1 -: 4];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_next = (PREFIX != 0) ? S_PFX0 : S_DIGIT;
            S_PFX0:  if (bus.tx_ready) w_next = S_PFX1;
            S_PFX1:  if (bus.tx_ready) w_next = S_DIGIT;
            S_DIGIT: if (bus.tx_ready && (r_cnt == '0))
                         w_next = (NEWLINE != 0) ? S_CR : S_IDLE;
            S_CR:    if (bus.tx_ready) w_next = S_LF;
            S_LF:    if (bus.tx_ready) w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    // The counter holds at zero on the last digit so it can never wrap.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= bus.in_data;
            r_cnt   <= C_LAST;
        end else if ((r_state == S_DIGIT) && bus.tx_ready) begin
            r_shift <= r_shift << 4;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Valid is masked during the ack cycle so tty_tx cannot restart on the old byte.
    always_comb begin
        bus.in_ready = (r_state == S_IDLE);
        bus.tx_valid = (r_state != S_IDLE) && !bus.tx_ready;
        case (r_state)
            S_PFX0:  bus.tx_data = 8'h30;
            S_PFX1:  bus.tx_data = 8'h78;
            S_DIGIT: bus.tx_data = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                                   : (8'h37 + {4'h0, w_nib});
            S_CR:    bus.tx_data = 8'h0D;
            S_LF:    bus.tx_data = 8'h0A;
            default: bus.tx_data = 8'h00;
        endcase
    end

endmodule
`default_nettype wire
